pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the instruction-fetch path. It holds the instruction-memory address and supports increment, absolute load, signed relative branch and clear, plus a hardware call/return stack and a stall input. It replaces the fixed 8-bit PC and 2:1 source mux. It feeds the instruction-memory address bus and is driven by the control unit's strobes.

## Interface
- AW, 8, PC / address width in bits (≥ 2)
- OFF_W, 4, relative-branch offset width, signed two's complement (2 ≤ OFF_W ≤ AW)
- DEPTH, 4, return-stack entries (≥ 1; ignored when stack compiled out)
- SPW, $clog2(DEPTH+1), stack-occupancy width (derived, not overridden)

- CLK  in  1  clock, all state updates on rising edge
- CLB  in  1  reset, synchronous, active-low
- stall  in  1  freeze all state this cycle (except reset)
- inc  in  1  advance PC by 1
- load  in  1  load branch target
- sel_rel  in  1  target source: 0 = tgt_abs, 1 = pc + sign-extended off
- tgt_abs  in  AW  absolute target
- off  in  OFF_W  signed relative offset
- call  in  1  push pc+1, jump to target
- ret  in  1  pop return address into PC
- pc  out  AW  current PC (registered)
- sp  out  SPW  stack occupancy, 0..DEPTH
- ovf  out  1  sticky: call attempted with stack full
- udf  out  1  sticky: ret attempted with stack empty

## Operation
- Target T = sel_rel ? (pc + sext(off)) mod 2^AW : tgt_abs.
- Priority per cycle, highest first:
  1. !CLB: pc=0, sp=0, ovf=0, udf=0, stack contents don't-care.
  2. stall: hold everything.
  3. ret: if sp>0, pc=top, sp−1. If empty, pc=pc+1, udf=1.
  4. call: if sp<DEPTH, push (pc+1) mod 2^AW, sp+1, pc=T. If full, pc=T, no push, ovf=1.
  5. load & inc: pc=0 (clear op). Stack untouched.
  6. load: pc=T.
  7. inc: pc=pc+1.
  8. none: hold.
- A lower-priority strobe asserted alongside a higher one is ignored, with no side effects.
- All arithmetic wraps modulo 2^AW: 2^AW−1 + 1 = 0. A relative branch below 0 wraps to the top.
- ovf and udf stay set until reset. They do not block further operation.
- The stack is a LIFO. Depth behaviour holds exactly at sp=0 and sp=DEPTH.

## Timing
- Single clock domain, no internal clock division. One decision per rising CLK edge.
- Latency: the effect of strobes sampled at edge n is visible on pc/sp/ovf/udf after edge n. There are no combinational paths from inputs to outputs.
- Reset is sampled like any input. Asserting it mid-sequence (e.g. sp=3) clears everything at the next edge regardless of stall or strobes.
- A call followed by a ret on the next cycle returns to call-site+1 with sp restored.
- Back-to-back call/ret in consecutive cycles is fully supported. No bubble is required.

## Configuration
- PC_RET_STACK_EN defined: behaviour as above.
- PC_RET_STACK_EN undefined:
  - stack storage and pointer are removed.
  - call behaves exactly as load.
  - ret behaves exactly as inc.
  - sp, ovf and udf are tied to 0.
  - DEPTH is unused.

## Structure
- Shared package pc_seq_pkg:
  - op-select enum PC_HOLD, PC_INC, PC_LOAD, PC_CLR, PC_CALL, PC_RET.
  - a function for priority decode of the strobes into that enum.
- Top-level contents: next-PC mux, adder and target computation.
- Sub-module pc_ret_stack (AW, DEPTH): LIFO with push/pop/full/empty/top/count. It is instantiated only under PC_RET_STACK_EN.

## Test plan
(AW=8, OFF_W=4, DEPTH=4)
- Reset then 3 cycles inc → pc 0,1,2,3. inc from pc=8'hFF → pc=8'h00.
- pc=8'h10, load sel_rel=1 off=4'b1100 (−4) → pc=8'h0C. pc=8'h02, off=−4 → pc=8'hFE. sel_rel=0 tgt_abs=8'hA5 → 8'hA5.
- load&inc at pc=8'h33 → pc=0. Same with stall=1 → pc stays 8'h33.
- Five calls from pc=10,20,30,40,50 (tgt 20,30,40,50,60):
  - after the 5th call: ovf=1, sp=4, pc=60.
  - four rets then give 51? No: fifth push dropped, so the rets give 41,31,21,11 and sp=0.
  - a fifth ret gives pc=12, udf=1.
- call and ret asserted together with sp=1 (top=8'h21) → ret wins, pc=8'h21, sp=0, no push.
- Reset asserted with sp=3, ovf=1, stall=1 → next edge pc=0, sp=0, ovf=0, udf=0. With PC_RET_STACK_EN undefined: call to 8'h40 → pc=8'h40, sp=0. Then ret → pc=8'h41.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: operation select and
// the priority decode that turns control-unit strobes into one operation.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_LOAD = 3'd2,
        PC_CLR  = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5
    } pc_op_e;

    // Highest-priority strobe wins; load together with inc means clear.
    function automatic pc_op_e pc_decode(input logic inc, input logic load,
                                         input logic call, input logic ret);
        pc_op_e op;
        op = PC_HOLD;
        if (ret)
            op = PC_RET;
        else if (call)
            op = PC_CALL;
        else if (load && inc)
            op = PC_CLR;
        else if (load)
            op = PC_LOAD;
        else if (inc)
            op = PC_INC;
        return op;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. A push while full or a pop while empty is ignored;
// the caller is responsible for flagging those cases.
module pc_ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [AW-1:0]  data_i,
    output logic [AW-1:0]  top_o,
    output logic [SPW-1:0] count_o,
    output logic           full_o,
    output logic           empty_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] count_q, count_d;
    logic [IW-1:0]  wr_idx, rd_idx;

    assign full_o  = (count_q == SPW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_idx  = IW'(count_q);
    assign rd_idx  = IW'(count_q - SPW'(1));
    assign top_o   = mem_q[rd_idx];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (pop_i && !empty_o)
            count_d = count_q - SPW'(1);
        else if (push_i && !full_o)
            count_d = count_q + SPW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Storage needs no reset: entries above count_q are never read.
    always_ff @(posedge clk_i) begin
        if (push_i && !pop_i && !full_o)
            mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, absolute/relative load, clear, stall,
// and a call/return stack that exists only when PC_RET_STACK_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int AW    = 8,
    parameter int OFF_W = 4,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             CLB,
    input  logic             stall,
    input  logic             inc,
    input  logic             load,
    input  logic             sel_rel,
    input  logic [AW-1:0]    tgt_abs,
    input  logic [OFF_W-1:0] off,
    input  logic             call,
    input  logic             ret,
    output logic [AW-1:0]    pc,
    output logic [SPW-1:0]   sp,
    output logic             ovf,
    output logic             udf
);
    logic [AW-1:0] pc_q, pc_d, pc_inc, off_ext, tgt;
    pc_op_e        op;

    assign off_ext = AW'($signed(off));
    assign pc_inc  = pc_q + AW'(1);
    assign tgt     = sel_rel ? (pc_q + off_ext) : tgt_abs;
    assign op      = pc_decode(inc, load, call, ret);
    assign pc      = pc_q;

`ifdef PC_RET_STACK_EN
    logic          push, pop, stk_full, stk_empty;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic [AW-1:0] stk_top;

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk_i   (CLK),
        .rst_ni  (CLB),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .count_o (sp),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign ovf = ovf_q;
    assign udf = udf_q;

    always_ff @(posedge CLK) begin
        if (!CLB) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
`else
    assign sp  = '0;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PC_RET_STACK_EN
        push  = 1'b0;
        pop   = 1'b0;
        ovf_d = ovf_q;
        udf_d = udf_q;
`endif
        if (!stall) begin
            case (op)
                PC_INC:  pc_d = pc_inc;
                PC_LOAD: pc_d = tgt;
                PC_CLR:  pc_d = '0;
`ifdef PC_RET_STACK_EN
                PC_CALL: begin
                    pc_d  = tgt;
                    push  = !stk_full;
                    ovf_d = ovf_q | stk_full;
                end
                // An empty-stack return still advances so fetch keeps moving.
                PC_RET: begin
                    if (stk_empty) begin
                        pc_d  = pc_inc;
                        udf_d = 1'b1;
                    end else begin
                        pc_d = stk_top;
                        pop  = 1'b1;
                    end
                end
`else
                PC_CALL: pc_d = tgt;
                PC_RET:  pc_d = pc_inc;
`endif
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLB)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, hand-written stack
// sequences (build-dependent on PC_RET_STACK_EN) and a randomized model check.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam int AW    = 8;
    localparam int OFF_W = 4;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int M     = 1 << AW;

    logic             clk = 1'b0;
    logic             CLB, stall, inc, load, sel_rel, call, ret;
    logic [AW-1:0]    tgt_abs;
    logic [OFF_W-1:0] off;
    logic [AW-1:0]    pc;
    logic [SPW-1:0]   sp;
    logic             ovf, udf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.AW(AW), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
        .CLK(clk), .CLB(CLB), .stall(stall), .inc(inc), .load(load),
        .sel_rel(sel_rel), .tgt_abs(tgt_abs), .off(off), .call(call),
        .ret(ret), .pc(pc), .sp(sp), .ovf(ovf), .udf(udf)
    );

    typedef struct {
        bit clb, stall, inc, load, rel, call, ret;
        int tgt, off;
    } stim_t;

    typedef struct {
        stim_t s;
        int    exp_pc;
    } vec_t;

    // Reference model: PC as an integer, return stack as a queue.
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_udf;

    function automatic int sext(input int o);
        return (o >= (1 << (OFF_W - 1))) ? o - (1 << OFF_W) : o;
    endfunction

    function automatic void model_step(input stim_t s);
        int t;
        t = s.rel ? (((m_pc + sext(s.off)) % M) + M) % M : s.tgt;
        if (!s.clb) begin
            m_pc = 0; m_stk.delete(); m_ovf = 0; m_udf = 0;
        end else if (s.stall) begin
        end else if (s.ret) begin
`ifdef PC_RET_STACK_EN
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = (m_pc + 1) % M; m_udf = 1; end
`else
            m_pc = (m_pc + 1) % M;
`endif
        end else if (s.call) begin
`ifdef PC_RET_STACK_EN
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % M);
            else m_ovf = 1;
`endif
            m_pc = t;
        end else if (s.load && s.inc) m_pc = 0;
        else if (s.load) m_pc = t;
        else if (s.inc) m_pc = (m_pc + 1) % M;
    endfunction

    function automatic stim_t mk(input bit clb, input bit st, input bit i, input bit l,
                                 input bit r, input bit c, input bit rt,
                                 input int t, input int o);
        stim_t s;
        s.clb = clb; s.stall = st; s.inc = i; s.load = l; s.rel = r;
        s.call = c; s.ret = rt; s.tgt = t % M; s.off = o % (1 << OFF_W);
        return s;
    endfunction

    function automatic stim_t s_rst();            return mk(0,0,0,0,0,0,0,0,0); endfunction
    function automatic stim_t s_ld(input int t);  return mk(1,0,0,1,0,0,0,t,0); endfunction
    function automatic stim_t s_cl(input int t);  return mk(1,0,0,0,0,1,0,t,0); endfunction
    function automatic stim_t s_ret();            return mk(1,0,0,0,0,0,1,0,0); endfunction
    function automatic stim_t s_nop();            return mk(1,0,0,0,0,0,0,0,0); endfunction

    task automatic apply(input stim_t s);
        CLB = s.clb; stall = s.stall; inc = s.inc; load = s.load;
        sel_rel = s.rel; call = s.call; ret = s.ret;
        tgt_abs = AW'(s.tgt); off = OFF_W'(s.off);
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int epc, input int esp,
                           input int eovf, input int eudf);
        chk({nm, ".pc"},  32'(pc),  epc);
        chk({nm, ".sp"},  32'(sp),  esp);
        chk({nm, ".ovf"}, 32'(ovf), eovf);
        chk({nm, ".udf"}, 32'(udf), eudf);
    endtask

    vec_t vt[$];

    initial begin
        CLB = 0; stall = 0; inc = 0; load = 0; sel_rel = 0; call = 0; ret = 0;
        tgt_abs = '0; off = '0;

        // Directed table: valid in both builds, stack never used.
        vt.push_back('{s_rst(),                    'h00});
        vt.push_back('{mk(1,0,1,0,0,0,0,0,0),      'h01});
        vt.push_back('{mk(1,0,1,0,0,0,0,0,0),      'h02});
        vt.push_back('{mk(1,0,1,0,0,0,0,0,0),      'h03});
        vt.push_back('{s_ld('hFF),                 'hFF});
        vt.push_back('{mk(1,0,1,0,0,0,0,0,0),      'h00});
        vt.push_back('{s_ld('h10),                 'h10});
        vt.push_back('{mk(1,0,0,1,1,0,0,'h99,'hC), 'h0C});
        vt.push_back('{s_ld('h02),                 'h02});
        vt.push_back('{mk(1,0,0,1,1,0,0,0,'hC),    'hFE});
        vt.push_back('{mk(1,0,0,1,1,0,0,0,'h7),    'h05});
        vt.push_back('{mk(1,0,0,1,0,0,0,'hA5,'h3), 'hA5});
        vt.push_back('{s_ld('h33),                 'h33});
        vt.push_back('{mk(1,1,1,1,0,0,0,0,0),      'h33});
        vt.push_back('{mk(1,0,1,1,0,0,0,'h44,0),   'h00});
        vt.push_back('{s_nop(),                    'h00});
        vt.push_back('{mk(1,1,1,0,0,0,0,0,0),      'h00});
        vt.push_back('{mk(0,1,1,1,0,0,0,'h12,0),   'h00});

        foreach (vt[i]) begin
            apply(vt[i].s);
            chk_all($sformatf("vec%0d", i), vt[i].exp_pc, 0, 0, 0);
        end

`ifdef PC_RET_STACK_EN
        apply(s_rst()); apply(s_ld('h10));
        apply(s_cl('h20)); chk_all("call1", 'h20, 1, 0, 0);
        apply(s_cl('h30)); apply(s_cl('h40)); apply(s_cl('h50));
        chk_all("call4", 'h50, 4, 0, 0);
        apply(s_cl('h60)); chk_all("call5_full", 'h60, 4, 1, 0);
        apply(s_ret()); chk_all("ret1", 'h41, 3, 1, 0);
        apply(s_ret()); chk_all("ret2", 'h31, 2, 1, 0);
        apply(s_ret()); chk_all("ret3", 'h21, 1, 1, 0);
        apply(s_ret()); chk_all("ret4", 'h11, 0, 1, 0);
        apply(s_ret()); chk_all("ret_empty", 'h12, 0, 1, 1);

        apply(s_rst()); apply(s_ld('h20)); apply(s_cl('h30));
        chk_all("cr_setup", 'h30, 1, 0, 0);
        apply(mk(1,0,0,0,0,1,1,'h77,0)); chk_all("call_ret_same", 'h21, 0, 0, 0);
        apply(s_nop()); chk_all("call_ret_nopush", 'h21, 0, 0, 0);

        apply(s_rst());
        for (int k = 1; k <= 5; k++) apply(s_cl(k));
        chk_all("fill", 5, 4, 1, 0);
        apply(s_ret()); chk_all("fill_ret", 4, 3, 1, 0);
        apply(mk(1,1,0,0,0,0,1,0,0)); chk_all("stall_ret", 4, 3, 1, 0);
        apply(mk(0,1,0,0,0,1,0,'h55,0)); chk_all("rst_mid", 0, 0, 0, 0);

        apply(s_ld('h40)); apply(s_cl('h80)); chk_all("b2b_call", 'h80, 1, 0, 0);
        apply(s_ret()); chk_all("b2b_ret", 'h41, 0, 0, 0);
`else
        apply(s_rst());
        apply(s_cl('h40)); chk_all("nostk_call", 'h40, 0, 0, 0);
        apply(s_ret());    chk_all("nostk_ret", 'h41, 0, 0, 0);
`endif

        // Randomized phase against the reference model.
        apply(s_rst());
        for (int n = 0; n < 3000; n++) begin
            stim_t s;
            s = mk($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 5) == 0,
                   int'($urandom_range(0, M - 1)),
                   int'($urandom_range(0, (1 << OFF_W) - 1)));
            apply(s);
            chk($sformatf("rand%0d.pc", n), 32'(pc), m_pc);
`ifdef PC_RET_STACK_EN
            chk($sformatf("rand%0d.sp", n), 32'(sp), m_stk.size());
`else
            chk($sformatf("rand%0d.sp", n), 32'(sp), 0);
`endif
            chk($sformatf("rand%0d.ovf", n), 32'(ovf), 32'(m_ovf));
            chk($sformatf("rand%0d.udf", n), 32'(udf), 32'(m_udf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
